// File: rtl/hd44780_pkg.sv
// Shared types and helpers for the HD44780 write-side bus driver.
// Holds the phase encoding, the slow command bytes and the long-wait decode.
package hd44780_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_WAIT
   } state_t;

   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_HOME     = 8'h02;
   // 0x03 also decodes as return-home on the controller
   localparam logic [7:0] CMD_HOME_ALT = 8'h03;

   function automatic logic needs_long_wait(input logic       rs,
                                            input logic [7:0] data,
                                            input logic       force_long);
      return force_long ||
             (!rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT));
   endfunction

endpackage

// File: rtl/hd44780_bus_writer_delay_timer.sv
// Loadable down-counter: load with (cycles-1); done is high while the count is zero,
// so a phase loaded with N-1 ends after exactly N cycles.
module delay_timer #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [N-1:0] value,
   output logic         done
);

   logic [N-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/hd44780_bus_writer.sv
// HD44780 write-side bus driver: one byte or nibble per valid/ready transfer,
// with programmable setup, enable-pulse, hold and post-command wait times.
module hd44780_bus_writer
   import hd44780_pkg::*;
#(
   parameter bit FOUR_BIT       = 1'b0,
   parameter int SETUP_CYC      = 2,
   parameter int PULSE_CYC      = 12,
   parameter int HOLD_CYC       = 2,
   parameter int WAIT_SHORT_CYC = 2000,
   parameter int WAIT_LONG_CYC  = 80000
) (
   input  logic       clk,
   input  logic       rst,
   // Handshake: a transfer is accepted on a rising edge where in_valid && in_ready.
   // in_ready is high only in IDLE; requests while busy are ignored, not queued.
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_rs,
   input  logic [7:0] in_data,
   input  logic       in_nibble,
   input  logic       in_long,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [7:0] lcd_db,
   output state_t     dbg_state
);

   localparam int MAX_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int MAX_B = (HOLD_CYC > WAIT_SHORT_CYC) ? HOLD_CYC : WAIT_SHORT_CYC;
   localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int MAXC  = (MAX_C > WAIT_LONG_CYC) ? MAX_C : WAIT_LONG_CYC;
   localparam int TW    = (MAXC > 1) ? $clog2(MAXC) : 1;

   state_t        state, state_n;
   logic          accept;
   logic          timer_load;
   logic [TW-1:0] timer_value;
   logic          timer_done;
   logic [3:0]    lo_nibble_q;
   logic          beat_pending_q;
   logic          long_q;

   assign accept    = (state == ST_IDLE) && in_valid && in_ready;
   assign lcd_rw    = 1'b0;
   assign dbg_state = state;

   delay_timer #(.N(TW)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (timer_load),
      .value (timer_value),
      .done  (timer_done)
   );

   // Every phase entry reloads the timer with (phase length - 1)
   always_comb begin
      state_n     = state;
      timer_load  = 1'b0;
      timer_value = TW'(SETUP_CYC - 1);
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               state_n     = ST_SETUP;
               timer_load  = 1'b1;
               timer_value = TW'(SETUP_CYC - 1);
            end
         end
         ST_SETUP: begin
            if (timer_done) begin
               state_n     = ST_PULSE;
               timer_load  = 1'b1;
               timer_value = TW'(PULSE_CYC - 1);
            end
         end
         ST_PULSE: begin
            if (timer_done) begin
               state_n     = ST_HOLD;
               timer_load  = 1'b1;
               timer_value = TW'(HOLD_CYC - 1);
            end
         end
         ST_HOLD: begin
            if (timer_done) begin
               timer_load = 1'b1;
               if (beat_pending_q) begin
                  state_n     = ST_SETUP;
                  timer_value = TW'(SETUP_CYC - 1);
               end else begin
                  state_n     = ST_WAIT;
                  timer_value = long_q ? TW'(WAIT_LONG_CYC - 1) : TW'(WAIT_SHORT_CYC - 1);
               end
            end
         end
         ST_WAIT: begin
            if (timer_done) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= ST_IDLE;
         in_ready       <= 1'b0;
         lcd_e          <= 1'b0;
         lcd_rs         <= 1'b0;
         lcd_db         <= 8'h00;
         lo_nibble_q    <= 4'h0;
         beat_pending_q <= 1'b0;
         long_q         <= 1'b0;
      end else begin
         state    <= state_n;
         in_ready <= (state_n == ST_IDLE);
         lcd_e    <= (state_n == ST_PULSE);
         if (accept) begin
            lcd_rs         <= in_rs;
            lcd_db         <= FOUR_BIT ? {in_data[7:4], 4'h0} : in_data;
            lo_nibble_q    <= in_data[3:0];
            beat_pending_q <= FOUR_BIT && !in_nibble;
            long_q         <= needs_long_wait(in_rs, in_data, in_long);
         end else if (state == ST_HOLD && state_n == ST_SETUP) begin
            // second beat of a 4-bit byte carries the low nibble on the upper lines
            lcd_db         <= {lo_nibble_q, 4'h0};
            beat_pending_q <= 1'b0;
         end
      end
   end

endmodule
